// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / EXT) arbiter for a single-port memory with a fixed read latency.
// One transaction at a time; ties are broken round-robin against the last-served requester.
module mem_port_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          ext_req,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic          ext_gnt,
   output logic          ext_ack,
   output logic [DW-1:0] ext_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   typedef enum logic {CPU, EXT} requester_t;

   localparam logic [1:0] WAIT_INIT = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

   state_t          state;
   requester_t      owner;
   requester_t      last;
   logic [AW-1:0]   cmd_addr;
   logic [DW-1:0]   cmd_wdata;
   logic [1:0]      cnt;
   logic            pick_ext;

   // EXT wins when alone, or on a tie when the CPU was served last.
   assign pick_ext = ext_req & (~cpu_req | (last == CPU));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         owner     <= CPU;
         last      <= EXT;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         cnt       <= '0;
         cpu_gnt   <= 1'b0;
         ext_gnt   <= 1'b0;
         cpu_ack   <= 1'b0;
         ext_ack   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         ext_ack <= 1'b0;
         mem_en  <= 1'b0;
         mem_we  <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req | ext_req) begin
                  owner     <= pick_ext ? EXT : CPU;
                  cmd_addr  <= pick_ext ? ext_addr  : cpu_addr;
                  cmd_wdata <= pick_ext ? ext_wdata : cpu_wdata;
                  mem_en    <= 1'b1;
                  mem_we    <= pick_ext ? ext_we : cpu_we;
                  cpu_gnt   <= ~pick_ext;
                  ext_gnt   <= pick_ext;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (MEM_LAT == 1) begin
                  cpu_ack <= (owner == CPU);
                  ext_ack <= (owner == EXT);
                  state   <= DONE;
               end else begin
                  cnt   <= WAIT_INIT;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  cpu_ack <= (owner == CPU);
                  ext_ack <= (owner == EXT);
                  state   <= DONE;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            DONE: begin
               last    <= owner;
               cpu_gnt <= 1'b0;
               ext_gnt <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               cpu_gnt <= 1'b0;
               ext_gnt <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   // Memory data arrives in the DONE cycle itself, so rdata is gated, not registered.
   assign cpu_rdata = cpu_ack ? mem_rdata : '0;
   assign ext_rdata = ext_ack ? mem_rdata : '0;
   assign mem_addr  = cmd_addr;
   assign mem_wdata = cmd_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table on a MEM_LAT=1 instance,
// plus hand sequences for latency, reset and withdrawal corners on MEM_LAT=1/3 instances.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, ext_req = 1'b0, ext_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0, ext_addr = '0, ext_wdata = '0, mem_rdata = '0;

   logic        d1_cpu_gnt, d1_cpu_ack, d1_ext_gnt, d1_ext_ack, d1_mem_en, d1_mem_we;
   logic [31:0] d1_cpu_rdata, d1_ext_rdata, d1_mem_addr, d1_mem_wdata;
   logic        d3_cpu_gnt, d3_cpu_ack, d3_ext_gnt, d3_ext_ack, d3_mem_en, d3_mem_we;
   logic [31:0] d3_cpu_rdata, d3_ext_rdata, d3_mem_addr, d3_mem_wdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) d1 (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(d1_cpu_gnt), .cpu_ack(d1_cpu_ack), .cpu_rdata(d1_cpu_rdata),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(d1_ext_gnt), .ext_ack(d1_ext_ack), .ext_rdata(d1_ext_rdata),
      .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr),
      .mem_wdata(d1_mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) d3 (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(d3_cpu_gnt), .cpu_ack(d3_cpu_ack), .cpu_rdata(d3_cpu_rdata),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(d3_ext_gnt), .ext_ack(d3_ext_ack), .ext_rdata(d3_ext_rdata),
      .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr),
      .mem_wdata(d3_mem_wdata), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        r, cq, cw, eq, ew;
      logic [31:0] ca, cd, ea, ed, mr;
      logic        gc, ac, ge, ae, en, we;
      logic [31:0] ma, md;
   } vec_t;

   function automatic vec_t v(logic r, logic cq, logic cw, logic [31:0] ca, logic [31:0] cd,
                              logic eq, logic ew, logic [31:0] ea, logic [31:0] ed,
                              logic [31:0] mr, logic gc, logic ac, logic ge, logic ae,
                              logic en, logic we, logic [31:0] ma, logic [31:0] md);
      vec_t x;
      x.r = r; x.cq = cq; x.cw = cw; x.ca = ca; x.cd = cd;
      x.eq = eq; x.ew = ew; x.ea = ea; x.ed = ed; x.mr = mr;
      x.gc = gc; x.ac = ac; x.ge = ge; x.ae = ae; x.en = en; x.we = we;
      x.ma = ma; x.md = md;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      cyc();
      rst = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; ext_req = 1'b0; ext_we = 1'b0;
      cyc();
      rst = 1'b1;
   endtask

   vec_t tbl[$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // rst cq cw caddr cwdata  eq ew eaddr ewdata mem_rdata  gc ac ge ae en we maddr mwdata
      tbl.push_back(v(0, 0,0, 32'h00, 32'h0,        0,0, 32'h00, 32'h0, 32'h0,        0,0,0,0, 0,0, 32'h00, 32'h0));
      tbl.push_back(v(1, 1,0, 32'h10, 32'h0,        0,0, 32'h00, 32'h0, 32'h0,        0,0,0,0, 0,0, 32'h00, 32'h0));
      tbl.push_back(v(1, 1,0, 32'h10, 32'h0,        0,0, 32'h00, 32'h0, 32'h0,        1,0,0,0, 1,0, 32'h10, 32'h0));
      tbl.push_back(v(1, 1,0, 32'h10, 32'h0,        0,0, 32'h00, 32'h0, 32'hDEADBEEF, 1,1,0,0, 0,0, 32'h10, 32'h0));
      tbl.push_back(v(1, 0,0, 32'h10, 32'h0,        0,0, 32'h00, 32'h0, 32'hDEADBEEF, 0,0,0,0, 0,0, 32'h10, 32'h0));
      tbl.push_back(v(0, 0,0, 32'h10, 32'h0,        0,0, 32'h80, 32'h0, 32'hDEADBEEF, 0,0,0,0, 0,0, 32'h00, 32'h0));
      tbl.push_back(v(1, 1,0, 32'h10, 32'h0,        1,0, 32'h80, 32'h0, 32'h0,        0,0,0,0, 0,0, 32'h00, 32'h0));
      tbl.push_back(v(1, 1,0, 32'h10, 32'h0,        1,0, 32'h80, 32'h0, 32'h0,        1,0,0,0, 1,0, 32'h10, 32'h0));
      tbl.push_back(v(1, 1,0, 32'h10, 32'h0,        1,0, 32'h80, 32'h0, 32'h11110002, 1,1,0,0, 0,0, 32'h10, 32'h0));
      tbl.push_back(v(1, 1,0, 32'h10, 32'h0,        1,0, 32'h80, 32'h0, 32'h0,        0,0,0,0, 0,0, 32'h10, 32'h0));
      tbl.push_back(v(1, 1,0, 32'h10, 32'h0,        1,0, 32'h80, 32'h0, 32'h0,        0,0,1,0, 1,0, 32'h80, 32'h0));
      tbl.push_back(v(1, 1,0, 32'h10, 32'h0,        1,0, 32'h80, 32'h0, 32'h22220005, 0,0,1,1, 0,0, 32'h80, 32'h0));
      tbl.push_back(v(1, 1,0, 32'h10, 32'h0,        1,0, 32'h80, 32'h0, 32'h0,        0,0,0,0, 0,0, 32'h80, 32'h0));
      tbl.push_back(v(1, 1,0, 32'h10, 32'h0,        1,0, 32'h80, 32'h0, 32'h0,        1,0,0,0, 1,0, 32'h10, 32'h0));
      tbl.push_back(v(1, 1,0, 32'h10, 32'h0,        1,0, 32'h80, 32'h0, 32'h33330008, 1,1,0,0, 0,0, 32'h10, 32'h0));
      tbl.push_back(v(1, 1,0, 32'h10, 32'h0,        1,0, 32'h80, 32'h0, 32'h0,        0,0,0,0, 0,0, 32'h10, 32'h0));
      tbl.push_back(v(1, 1,0, 32'h10, 32'h0,        1,0, 32'h80, 32'h0, 32'h0,        0,0,1,0, 1,0, 32'h80, 32'h0));
      tbl.push_back(v(1, 1,0, 32'h10, 32'h0,        1,0, 32'h80, 32'h0, 32'h4444000B, 0,0,1,1, 0,0, 32'h80, 32'h0));
      tbl.push_back(v(1, 0,0, 32'h10, 32'h0,        0,0, 32'h80, 32'h0, 32'h0,        0,0,0,0, 0,0, 32'h80, 32'h0));
      tbl.push_back(v(1, 1,1, 32'h24, 32'hCAFEF00D, 0,0, 32'h80, 32'h0, 32'h0,        0,0,0,0, 0,0, 32'h80, 32'h0));
      tbl.push_back(v(1, 1,1, 32'h24, 32'hCAFEF00D, 0,0, 32'h80, 32'h0, 32'h0,        1,0,0,0, 1,1, 32'h24, 32'hCAFEF00D));
      tbl.push_back(v(1, 1,1, 32'h24, 32'hCAFEF00D, 0,0, 32'h80, 32'h0, 32'h5555,     1,1,0,0, 0,0, 32'h24, 32'hCAFEF00D));
      tbl.push_back(v(1, 0,0, 32'h24, 32'hCAFEF00D, 0,0, 32'h80, 32'h0, 32'h5555,     0,0,0,0, 0,0, 32'h24, 32'hCAFEF00D));

      foreach (tbl[i]) begin
         cyc();
         rst = tbl[i].r; cpu_req = tbl[i].cq; cpu_we = tbl[i].cw;
         cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
         ext_req = tbl[i].eq; ext_we = tbl[i].ew;
         ext_addr = tbl[i].ea; ext_wdata = tbl[i].ed; mem_rdata = tbl[i].mr;
         @(negedge clk);
         chk($sformatf("v%0d cpu_gnt", i), 32'(d1_cpu_gnt), 32'(tbl[i].gc));
         chk($sformatf("v%0d cpu_ack", i), 32'(d1_cpu_ack), 32'(tbl[i].ac));
         chk($sformatf("v%0d ext_gnt", i), 32'(d1_ext_gnt), 32'(tbl[i].ge));
         chk($sformatf("v%0d ext_ack", i), 32'(d1_ext_ack), 32'(tbl[i].ae));
         chk($sformatf("v%0d mem_en", i), 32'(d1_mem_en), 32'(tbl[i].en));
         chk($sformatf("v%0d mem_we", i), 32'(d1_mem_we), 32'(tbl[i].we));
         chk($sformatf("v%0d mem_addr", i), d1_mem_addr, tbl[i].ma);
         chk($sformatf("v%0d mem_wdata", i), d1_mem_wdata, tbl[i].md);
         chk($sformatf("v%0d cpu_rdata", i), d1_cpu_rdata, tbl[i].ac ? tbl[i].mr : 32'h0);
         chk($sformatf("v%0d ext_rdata", i), d1_ext_rdata, tbl[i].ae ? tbl[i].mr : 32'h0);
      end

      // EXT write, MEM_LAT=3: strobe only in ISSUE, ack three cycles later.
      do_reset();
      mem_rdata = 32'hDEADBEEF;
      cyc();
      ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h40; ext_wdata = 32'h12345678;
      @(negedge clk);
      chk("wr c0 ext_gnt", 32'(d3_ext_gnt), 32'd0);
      for (int c = 1; c <= 4; c++) begin
         cyc();
         @(negedge clk);
         chk($sformatf("wr c%0d mem_en", c), 32'(d3_mem_en), 32'(c == 1));
         chk($sformatf("wr c%0d mem_we", c), 32'(d3_mem_we), 32'(c == 1));
         chk($sformatf("wr c%0d ext_gnt", c), 32'(d3_ext_gnt), 32'd1);
         chk($sformatf("wr c%0d ext_ack", c), 32'(d3_ext_ack), 32'(c == 4));
         chk($sformatf("wr c%0d cpu_gnt", c), 32'(d3_cpu_gnt), 32'd0);
         chk($sformatf("wr c%0d mem_addr", c), d3_mem_addr, 32'h40);
         chk($sformatf("wr c%0d mem_wdata", c), d3_mem_wdata, 32'h12345678);
      end
      cyc();
      ext_req = 1'b0; ext_we = 1'b0;
      @(negedge clk);
      chk("wr c5 ext_gnt", 32'(d3_ext_gnt), 32'd0);

      // Address change after grant is ignored.
      do_reset();
      cyc();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
      cyc();
      @(negedge clk);
      chk("chg c1 mem_addr", d3_mem_addr, 32'h20);
      for (int c = 2; c <= 4; c++) begin
         cyc();
         cpu_addr = 32'h99;
         @(negedge clk);
         chk($sformatf("chg c%0d mem_addr", c), d3_mem_addr, 32'h20);
         chk($sformatf("chg c%0d cpu_ack", c), 32'(d3_cpu_ack), 32'(c == 4));
         chk($sformatf("chg c%0d cpu_rdata", c), d3_cpu_rdata, (c == 4) ? 32'hDEADBEEF : 32'h0);
      end
      cyc();
      cpu_req = 1'b0;

      // Reset mid-WAIT with an EXT read in flight.
      do_reset();
      cyc();
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h44; ext_wdata = 32'h77;
      cyc();
      @(negedge clk);
      chk("rw issue mem_en", 32'(d3_mem_en), 32'd1);
      cyc();
      @(negedge clk);
      chk("rw wait ext_gnt", 32'(d3_ext_gnt), 32'd1);
      #2;
      rst = 1'b0; ext_req = 1'b0;
      #1;
      chk("rw rst cpu_gnt", 32'(d3_cpu_gnt), 32'd0);
      chk("rw rst cpu_ack", 32'(d3_cpu_ack), 32'd0);
      chk("rw rst ext_gnt", 32'(d3_ext_gnt), 32'd0);
      chk("rw rst ext_ack", 32'(d3_ext_ack), 32'd0);
      chk("rw rst mem_en", 32'(d3_mem_en), 32'd0);
      chk("rw rst mem_we", 32'(d3_mem_we), 32'd0);
      chk("rw rst mem_addr", d3_mem_addr, 32'h0);
      chk("rw rst mem_wdata", d3_mem_wdata, 32'h0);
      chk("rw rst cpu_rdata", d3_cpu_rdata, 32'h0);
      chk("rw rst ext_rdata", d3_ext_rdata, 32'h0);
      cyc();
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         cyc();
         @(negedge clk);
         chk($sformatf("rw post%0d ext_ack", c), 32'(d3_ext_ack), 32'd0);
         chk($sformatf("rw post%0d mem_en", c), 32'(d3_mem_en), 32'd0);
         chk($sformatf("rw post%0d ext_gnt", c), 32'(d3_ext_gnt), 32'd0);
      end

      // Withdrawn EXT pulse during a CPU ISSUE, MEM_LAT=1.
      do_reset();
      cyc();
      cpu_req = 1'b1; cpu_addr = 32'h30;
      cyc();
      ext_req = 1'b1; ext_addr = 32'h50;
      @(negedge clk);
      chk("wd c1 cpu_gnt", 32'(d1_cpu_gnt), 32'd1);
      cyc();
      ext_req = 1'b0;
      @(negedge clk);
      chk("wd c2 cpu_ack", 32'(d1_cpu_ack), 32'd1);
      for (int c = 3; c <= 4; c++) begin
         cyc();
         cpu_req = 1'b0;
         @(negedge clk);
         chk($sformatf("wd c%0d ext_gnt", c), 32'(d1_ext_gnt), 32'd0);
         chk($sformatf("wd c%0d mem_en", c), 32'(d1_mem_en), 32'd0);
      end
      ext_req = 1'b1; ext_addr = 32'h60;
      cyc();
      @(negedge clk);
      chk("wd c5 ext_gnt", 32'(d1_ext_gnt), 32'd1);
      chk("wd c5 mem_addr", d1_mem_addr, 32'h60);
      cyc();
      ext_req = 1'b0;
      @(negedge clk);
      chk("wd c6 ext_ack", 32'(d1_ext_ack), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
